// File: rtl/alu_seq16.sv
// Nibble-serial ALU: steps one 74181-style 4-bit slice across a 4*NIBBLES-bit
// operand pair, LSB first, with valid/ready handshakes and C/Z/N/V flags.

module alu_74181 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic [3:0] s,
  input  logic       m,
  input  logic       cn,
  output logic [3:0] f,
  output logic       cn4
);
  logic [3:0] x;
  logic [3:0] y;
  logic [4:0] c;

  // x/y are the inverted generate/propagate terms; c is an active-high carry chain
  always_comb begin
    x = ~((a & b & {4{s[3]}}) | (a & ~b & {4{s[2]}}));
    y = ~(a | (b & {4{s[0]}}) | (~b & {4{s[1]}}));
    c = '0;
    c[0] = ~cn;
    for (int i = 0; i < 4; i++) begin
      c[i+1] = ~x[i] | (~y[i] & c[i]);
    end
    f   = (x ^ y) ^ ({4{m}} | c[3:0]);
    cn4 = ~c[4];
  end
endmodule

// state | meaning
// IDLE  | in_ready high, waiting for a request
// RUN   | one slice step per cycle, nibble idx_q
// DONE  | out_valid high, result/flags held until out_ready
module alu_seq16 #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2:0]           op,
  input  logic [4*NIBBLES-1:0] a,
  input  logic [4*NIBBLES-1:0] b,
  input  logic                 cin,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [4*NIBBLES-1:0] result,
  output logic                 flag_c,
  output logic                 flag_z,
  output logic                 flag_n,
  output logic                 flag_v
);
  localparam int W     = 4 * NIBBLES;
  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_ADC = 3'b001;
  localparam logic [2:0] OP_SUB = 3'b010;
  localparam logic [2:0] OP_SBB = 3'b011;
  localparam logic [2:0] OP_AND = 3'b100;
  localparam logic [2:0] OP_OR  = 3'b101;
  localparam logic [2:0] OP_XOR = 3'b110;
  localparam logic [2:0] OP_CMP = 3'b111;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_q, state_d;
  logic [W-1:0]       a_q, b_q, res_q, result_q;
  logic [2:0]         op_q;
  logic               carry_q;
  logic [IDX_W-1:0]   idx_q;
  logic               fc_q, fz_q, fn_q, fv_q;

  logic               accept, last_step;
  logic               first_cn;
  logic [3:0]         slice_s, slice_f;
  logic               slice_m, slice_cn, slice_cn4;
  logic               is_add, is_sub;
  logic [W-1:0]       r_full;
  logic               flag_c_d, flag_v_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    accept    = 1'b0;
    last_step = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (idx_q == IDX_W'(NIBBLES - 1)) begin
          last_step = 1'b1;
          state_d   = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // carry register holds the active-low Cn of the next step
  always_comb begin
    case (op)
      OP_ADD:         first_cn = 1'b1;
      OP_ADC:         first_cn = ~cin;
      OP_SUB, OP_CMP: first_cn = 1'b0;
      OP_SBB:         first_cn = cin;
      default:        first_cn = 1'b1;
    endcase
  end

  always_comb begin
    slice_s = 4'b1001;
    slice_m = 1'b0;
    is_add  = 1'b0;
    is_sub  = 1'b0;
    case (op_q)
      OP_ADD, OP_ADC: is_add = 1'b1;
      OP_SUB, OP_SBB, OP_CMP: begin
        slice_s = 4'b0110;
        is_sub  = 1'b1;
      end
      OP_AND: begin
        slice_s = 4'b1011;
        slice_m = 1'b1;
      end
      OP_OR: begin
        slice_s = 4'b1110;
        slice_m = 1'b1;
      end
      OP_XOR: begin
        slice_s = 4'b0110;
        slice_m = 1'b1;
      end
      default: ;
    endcase
    slice_cn = (is_add | is_sub) ? carry_q : 1'b1;
  end

  alu_74181 u_slice (
    .a   (a_q[4*idx_q +: 4]),
    .b   (b_q[4*idx_q +: 4]),
    .s   (slice_s),
    .m   (slice_m),
    .cn  (slice_cn),
    .f   (slice_f),
    .cn4 (slice_cn4)
  );

  // full-width value including the nibble produced this cycle
  always_comb begin
    r_full = res_q;
    r_full[4*idx_q +: 4] = slice_f;
    flag_c_d = 1'b0;
    flag_v_d = 1'b0;
    if (is_add) begin
      flag_c_d = ~slice_cn4;
      flag_v_d = (a_q[W-1] == b_q[W-1]) && (r_full[W-1] != a_q[W-1]);
    end else if (is_sub) begin
      flag_c_d = slice_cn4;
      flag_v_d = (a_q[W-1] != b_q[W-1]) && (r_full[W-1] != a_q[W-1]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= OP_ADD;
      carry_q  <= 1'b1;
      idx_q    <= '0;
      res_q    <= '0;
      result_q <= '0;
      fc_q     <= 1'b0;
      fz_q     <= 1'b0;
      fn_q     <= 1'b0;
      fv_q     <= 1'b0;
    end else if (accept) begin
      a_q     <= a;
      b_q     <= b;
      op_q    <= op;
      carry_q <= first_cn;
      idx_q   <= '0;
    end else if (state_q == RUN) begin
      res_q[4*idx_q +: 4] <= slice_f;
      carry_q             <= slice_cn4;
      if (last_step) begin
        idx_q    <= '0;
        result_q <= (op_q == OP_CMP) ? a_q : r_full;
        fc_q     <= flag_c_d;
        fz_q     <= (r_full == '0);
        fn_q     <= r_full[W-1];
        fv_q     <= flag_v_d;
      end else begin
        idx_q <= idx_q + IDX_W'(1);
      end
    end
  end

  assign result = result_q;
  assign flag_c = fc_q;
  assign flag_z = fz_q;
  assign flag_n = fn_q;
  assign flag_v = fv_q;
endmodule

// File: tb/tb_alu_seq16.sv
// Self-checking bench for alu_seq16: directed vector table, handshake/reset
// corner sequences and randomized operations against an arithmetic model.

module tb_alu_seq16;
  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  op;
  logic [15:0] a, b;
  logic        cin;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;
  logic        flag_c, flag_z, flag_n, flag_v;

  int total = 0;
  int bad   = 0;

  alu_seq16 #(.NIBBLES(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flag_c    (flag_c),
    .flag_z    (flag_z),
    .flag_n    (flag_n),
    .flag_v    (flag_v)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] res;
    logic        c, z, n, v;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // returns {result, c, z, n, v} from plain integer arithmetic
  function automatic logic [19:0] model(input logic [2:0] o, input logic [15:0] x,
                                        input logic [15:0] y, input logic ci);
    int unsigned ux, uy, sum, sub;
    logic [15:0] r;
    logic        c, v;
    ux = x; uy = y; c = 0; v = 0; r = 0;
    case (o)
      3'd0, 3'd1: begin
        sum = ux + uy + ((o == 3'd1) ? ci : 0);
        r = sum[15:0];
        c = sum > 65535;
        v = (x[15] == y[15]) && (r[15] != x[15]);
      end
      3'd2, 3'd3, 3'd7: begin
        sub = uy + ((o == 3'd3) ? ci : 0);
        r = 16'(ux - sub);
        c = ux < sub;
        v = (x[15] != y[15]) && (r[15] != x[15]);
      end
      3'd4: r = x & y;
      3'd5: r = x | y;
      default: r = x ^ y;
    endcase
    return {(o == 3'd7) ? x : r, c, r == 16'h0, r[15], v};
  endfunction

  task automatic run_op(input string name, input logic [2:0] o, input logic [15:0] x,
                        input logic [15:0] y, input logic ci, input logic [19:0] exp,
                        input int hold);
    int n;
    op = o; a = x; b = y; cin = ci; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    chk({name, "_accept_timeout"}, n < 20, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = $urandom; b = $urandom; op = 3'($urandom); cin = 1'($urandom);
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1; n++;
    end
    chk({name, "_latency"}, n, 4);
    chk({name, "_out"}, {result, flag_c, flag_z, flag_n, flag_v}, exp);
    for (int i = 0; i < hold; i++) begin
      a = $urandom; b = $urandom;
      @(posedge clk); #1;
      chk({name, "_hold_out"}, {result, flag_c, flag_z, flag_n, flag_v}, exp);
      chk({name, "_hold_in_ready"}, in_ready, 0);
      chk({name, "_hold_valid"}, out_valid, 1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({name, "_back_idle"}, {in_ready, out_valid}, 2'b10);
  endtask

  vec_t vecs[12];

  initial begin
    int n;
    vec_t v;
    logic [2:0] ro;
    logic [15:0] ra, rb;
    logic rc;

    vecs[0]  = '{3'd0, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 0, 0, 1, 1};
    vecs[1]  = '{3'd2, 16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1, 0, 1, 0};
    vecs[2]  = '{3'd1, 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1, 1, 0, 0};
    vecs[3]  = '{3'd3, 16'h1000, 16'h0FFF, 1'b1, 16'h0000, 0, 1, 0, 0};
    vecs[4]  = '{3'd7, 16'h1234, 16'h1234, 1'b0, 16'h1234, 0, 1, 0, 0};
    vecs[5]  = '{3'd6, 16'hA5A5, 16'hFFFF, 1'b0, 16'h5A5A, 0, 0, 0, 0};
    vecs[6]  = '{3'd4, 16'hF0F0, 16'h3C3C, 1'b0, 16'h3030, 0, 0, 0, 0};
    vecs[7]  = '{3'd5, 16'h0F00, 16'h00F0, 1'b0, 16'h0FF0, 0, 0, 0, 0};
    vecs[8]  = '{3'd2, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 0, 0, 0, 1};
    vecs[9]  = '{3'd0, 16'hFFFF, 16'h0001, 1'b1, 16'h0000, 1, 1, 0, 0};
    vecs[10] = '{3'd7, 16'h0001, 16'h0002, 1'b0, 16'h0001, 1, 0, 1, 0};
    vecs[11] = '{3'd4, 16'hAAAA, 16'h5555, 1'b1, 16'h0000, 0, 1, 0, 0};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    op = 3'd0; a = 16'h0; b = 16'h0; cin = 1'b0;
    #1;
    chk("reset_state", {in_ready, out_valid, result, flag_c, flag_z, flag_n, flag_v},
        {1'b1, 1'b0, 16'h0, 4'h0});
    #21 rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 12; i++) begin
      v = vecs[i];
      run_op($sformatf("vec%0d", i), v.op, v.a, v.b, v.cin,
             {v.res, v.c, v.z, v.n, v.v}, 0);
    end

    // backpressure: DONE held for 5 cycles
    run_op("backpressure", 3'd0, 16'h7FFF, 16'h0001, 1'b0, {16'h8000, 4'b0011}, 5);

    // reset during RUN step 2
    op = 3'd0; a = 16'h1111; b = 16'h2222; cin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("midrun_reset_hs", {in_ready, out_valid}, 2'b10);
    chk("midrun_reset_out", {result, flag_c, flag_z, flag_n, flag_v}, 20'h0);
    n = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (out_valid) n++;
    end
    chk("midrun_reset_no_valid", n, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    run_op("after_reset_add", 3'd0, 16'h1234, 16'h4321, 1'b0, {16'h5555, 4'b0000}, 0);

    // in_valid held high across completion: one accept per IDLE visit
    op = 3'd0; a = 16'h0001; b = 16'h0002; cin = 1'b0;
    in_valid = 1'b1; out_ready = 1'b1;
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1; n++;
    end
    chk("stream_first_timeout", n < 20, 1);
    for (int k = 0; k < 2; k++) begin
      n = 0;
      do begin
        @(posedge clk); #1; n++;
      end while (!out_valid && n < 20);
      chk("stream_gap", n, 6);
      chk("stream_out", {result, flag_c, flag_z, flag_n, flag_v}, {16'h0003, 4'b0000});
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("stream_drain_idle", {in_ready, out_valid}, 2'b10);

    // randomized operations with random backpressure and input scrambling
    for (int i = 0; i < 150; i++) begin
      ro = 3'($urandom);
      ra = 16'($urandom);
      rb = 16'($urandom);
      rc = 1'($urandom);
      if (i % 5 == 0) rb = ra;
      run_op("rand", ro, ra, rb, rc, model(ro, ra, rb, rc), int'($urandom_range(0, 3)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/alu_seq16.md
# alu_seq16

Multi-cycle sequencer wrapping one `alu_74181` slice: performs a `4*NIBBLES`-bit arithmetic/logic operation by stepping the 4-bit slice across the operand one nibble per cycle, LSB first.
- Ripple carry is chained through a register: `Cn4` of one step feeds `Cn` of the next.
- Operands and results use valid/ready handshakes, so the block sits between a register file/decoder and a writeback stage.
- Produces C/Z/N/V flags.

## Interface
Parameters:
- `NIBBLES`, default 4: slice steps per operation; data width `W = 4*NIBBLES`.

Ports:
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: reset, asynchronous and active-low.
- `in_valid` in 1: operation request.
- `in_ready` out 1: block can accept a request.
- `op` in 3: operation code.
  - 000 ADD, 001 ADC, 010 SUB, 011 SBB.
  - 100 AND, 101 OR, 110 XOR, 111 CMP.
- `a`, `b` in W: operands.
- `cin` in 1: active-high carry-in (ADC) or borrow-in (SBB).
- `out_valid` out 1: result available.
- `out_ready` in 1: consumer accepts result.
- `result` out W: operation result.
- `flag_c` out 1: carry (ADD/ADC) or borrow (SUB/SBB/CMP); 0 for logic ops.
- `flag_z` out 1: flag-source value == 0.
- `flag_n` out 1: MSB of flag-source value.
- `flag_v` out 1: signed overflow; 0 for logic ops.

## Operation
FSM states: IDLE, RUN, DONE.
- **IDLE**
  - `in_ready`=1.
  - On `in_valid && in_ready`: latch `a`, `b`, `op`, `cin`; clear nibble index `idx`; load the carry register with the first-step `Cn`; go to RUN.
- **RUN**
  - Drive the slice: `A=a[4*idx+:4]`, `B=b[4*idx+:4]`, plus `S/M/Cn` per op.
  - At the clock edge: store `F` into `res[4*idx+:4]`; load the carry register from `Cn4`; `idx++`.
  - After step `idx==NIBBLES-1`, go to DONE.
- **DONE**
  - `out_valid`=1; `result`/flags held stable.
  - On `out_ready`: go to IDLE.
  - No new request is accepted in DONE.

Slice control (active-high data convention; `Cn` and `Cn4` are active-low carries):
- **ADD:** `M=0 S=1001`, first `Cn=1`.
- **ADC:** `M=0 S=1001`, first `Cn=~cin`.
- **SUB/CMP:** `M=0 S=0110`, first `Cn=0`.
- **SBB:** `M=0 S=0110`, first `Cn=cin`.
- **AND:** `M=1 S=1011`. **OR:** `M=1 S=1110`. **XOR:** `M=1 S=0110`. For all three, `Cn=1` and the carry register is ignored.

Flags, computed at entry to DONE from the final carry register `k` (= final `Cn4`) and full-width value `r`:
- `flag_c`:
  - ADD/ADC: `~k`.
  - SUB/SBB/CMP: `k` (borrow).
  - Logic ops: 0.
- `flag_v`:
  - ADD/ADC: `a[W-1]==b[W-1] && r[W-1]!=a[W-1]`.
  - SUB/SBB/CMP: `a[W-1]!=b[W-1] && r[W-1]!=a[W-1]`.
  - Logic ops: 0.
- `flag_z`: `r==0`. `flag_n`: `r[W-1]`.
- CMP: flags come from the difference, but `result` outputs latched `a`.

Width and arithmetic rules:
- Results wrap modulo `2^W`; no saturation.
- Operand latches are not modified during RUN.

## Timing
Reset values, applied immediately while `rst_n`=0:
- State IDLE; `in_ready`=1; `out_valid`=0; `result`=0; all flags 0; `idx`=0.

Latency and throughput:
- If a request is accepted at edge T0, the RUN steps occur at edges T1..T_NIBBLES.
- `out_valid` rises after edge T_NIBBLES (4 cycles for the default).
- If `out_ready` is high at the first DONE cycle, the block is back in IDLE one cycle later.
- Maximum throughput: one operation per `NIBBLES+2` cycles.

Handshake rules:
- `result`/flags must not change while `out_valid`=1 and `out_ready`=0.
- Input changes during RUN/DONE are ignored.
- `in_ready` is combinational from state only; there is no dependency on `in_valid`.

Boundary conditions:
- **Reset mid-RUN or mid-DONE:** abort immediately; no partial result is ever presented.
- **`in_valid` held high across completion:** the next request is accepted only in IDLE, one request per IDLE entry.
- **`NIBBLES=1`:** RUN lasts exactly one cycle.

## Test plan
- **ADD signed overflow:** `a=0x7FFF b=0x0001` → `result=0x8000`, C=0, Z=0, N=1, V=1; `out_valid` exactly 4 cycles after accept.
- **SUB borrow:** `a=0x0000 b=0x0001` → `0xFFFF`, C=1, N=1, V=0.
- **ADC full carry ripple:** `a=0xFFFF b=0x0000 cin=1` → `0x0000`, C=1, Z=1.
- **SBB / CMP:**
  - SBB `a=0x1000 b=0x0FFF cin=1` → `0x0000`, Z=1, C=0.
  - CMP `a=b=0x1234` → `result=0x1234`, Z=1, C=0.
- **Logic ops:**
  - XOR `0xA5A5^0xFFFF` → `0x5A5A`.
  - AND `0xF0F0&0x3C3C` → `0x3030`.
  - OR `0x0F00|0x00F0` → `0x0FF0`.
  - All three: C=0, V=0.
- **Backpressure and reset:**
  - Hold `out_ready`=0 for 5 cycles: result/flags stable, `in_ready`=0.
  - Drop `rst_n` during RUN step 2: `out_valid`=0 and `in_ready`=1 immediately.
  - A new ADD after reset computes correctly.
